// File: rtl/cache_set_ctrl.sv
// Blocking controller for one 8-line cache set: tag compare, store-hit write-through, allocate-on-miss line fetch.
// Optional hit/miss counters are compiled in with `define CACHE_CTRL_STATS_EN.
module cache_set_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [7:0]   cpu_wdata,
    output logic         cpu_done,
    output logic [7:0]   cpu_rdata,
    output logic [7:0]   c_dec,
    output logic [4:0]   c_offset,
    output logic [7:0]   c_byte,
    output logic [23:0]  c_tag,
    output logic         c_hit,
    output logic         c_mem_write,
    output logic         c_set_out,
    output logic         c_viv,
    output logic [255:0] c_fill,
    input  logic         line_valid,
    input  logic [23:0]  line_tag,
    input  logic [255:0] line_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic         mem_ack,
    input  logic [255:0] mem_rdata,
    output logic         mem_err
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    typedef enum logic [2:0] {IDLE, COMPARE, WRITE, FETCH, FILL, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [31:0] tmo_cnt;
    logic        hit;
    logic        tmo;

    assign hit = line_valid && (line_tag == addr_q[31:8]);
    assign tmo = (MEM_TIMEOUT != 0) && (tmo_cnt == MEM_TIMEOUT - 1);

    // Set-side controls come only from latched fields so the CPU port never reaches outputs.
    assign c_dec       = 8'b1 << addr_q[7:5];
    assign c_offset    = addr_q[4:0];
    assign c_tag       = addr_q[31:8];
    assign c_byte      = wdata_q;
    assign c_set_out   = (state == FILL);
    assign c_viv       = (state == FILL);
    assign cpu_done    = (state == DONE);
    assign mem_req     = (state == WRITE) || (state == FETCH);
    assign mem_we      = (state == WRITE);
    assign mem_wdata   = (state == WRITE) ? wdata_q : 8'h00;

    always_comb begin
        mem_addr = 32'h0;
        if (state == WRITE)
            mem_addr = addr_q;
        else if (state == FETCH)
            mem_addr = {addr_q[31:5], 5'b0};
    end

    always_comb begin
        state_nx    = state;
        c_hit       = 1'b0;
        c_mem_write = 1'b0;
        case (state)
            IDLE:    if (cpu_req) state_nx = COMPARE;
            COMPARE: begin
                if (hit && we_q) begin
                    c_hit       = 1'b1;
                    c_mem_write = 1'b1;
                    state_nx    = WRITE;
                end else if (hit) begin
                    state_nx = DONE;
                end else begin
                    state_nx = FETCH;
                end
            end
            WRITE:   if (mem_ack || tmo) state_nx = DONE;
            FETCH:   begin
                if (mem_ack)  state_nx = FILL;
                else if (tmo) state_nx = DONE;
            end
            FILL:    state_nx = COMPARE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= 32'h0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h0;
            cpu_rdata <= 8'h0;
            c_fill    <= 256'h0;
            mem_err   <= 1'b0;
            tmo_cnt   <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            if (state == COMPARE && hit && !we_q)
                cpu_rdata <= line_data[{addr_q[4:0], 3'b000} +: 8];
            if (state == FETCH && mem_ack)
                c_fill <= mem_rdata;
            if ((state == WRITE || state == FETCH) && !mem_ack && tmo)
                mem_err <= 1'b1;
            // WRITE and FETCH are always entered from another state, so this restarts the count.
            if (state == WRITE || state == FETCH)
                tmo_cnt <= tmo_cnt + 32'd1;
            else
                tmo_cnt <= 32'h0;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic relookup;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            relookup   <= 1'b0;
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if (state == FILL)
                relookup <= 1'b1;
            else if (state == IDLE)
                relookup <= 1'b0;
            if (state == COMPARE && !relookup) begin
                if (hit && hit_count != 16'hFFFF)
                    hit_count <= hit_count + 16'd1;
                else if (!hit && miss_count != 16'hFFFF)
                    miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl: behavioural 8-line set model, manual memory acks, load-result scoreboard.
module tb_cache_set_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic [7:0]   cpu_wdata = 8'h0;
    logic         cpu_done;
    logic [7:0]   cpu_rdata;
    logic [7:0]   c_dec;
    logic [4:0]   c_offset;
    logic [7:0]   c_byte;
    logic [23:0]  c_tag;
    logic         c_hit, c_mem_write, c_set_out, c_viv;
    logic [255:0] c_fill;
    logic         line_valid;
    logic [23:0]  line_tag;
    logic [255:0] line_data;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_ack = 1'b0;
    logic [255:0] mem_rdata = 256'h0;
    logic         mem_err;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    int fill_cnt = 0;
    logic [7:0] sb[$];

    cache_set_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .c_dec(c_dec), .c_offset(c_offset), .c_byte(c_byte), .c_tag(c_tag),
        .c_hit(c_hit), .c_mem_write(c_mem_write), .c_set_out(c_set_out), .c_viv(c_viv),
        .c_fill(c_fill),
        .line_valid(line_valid), .line_tag(line_tag), .line_data(line_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural cache set: selected by c_dec, written on the clock edge.
    logic         set_init = 1'b1;
    logic         sv_valid [8];
    logic [23:0]  sv_tag   [8];
    logic [255:0] sv_data  [8];
    logic [2:0]   sel;

    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++)
            if (c_dec[i]) sel = 3'(i);
    end

    assign line_valid = sv_valid[sel];
    assign line_tag   = sv_tag[sel];
    assign line_data  = sv_data[sel];

    always @(posedge clk) begin
        if (set_init) begin
            for (int i = 0; i < 8; i++) begin
                sv_valid[i] <= 1'b0;
                sv_tag[i]   <= 24'h0;
                sv_data[i]  <= 256'h0;
            end
        end else begin
            if (c_hit && c_mem_write)
                sv_data[sel][{c_offset, 3'b000} +: 8] <= c_byte;
            if (c_set_out) begin
                sv_valid[sel] <= 1'b1;
                sv_tag[sel]   <= c_tag;
                sv_data[sel]  <= c_fill;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_req)   req_cnt++;
        if (c_set_out) fill_cnt++;
    end

    function automatic logic [255:0] pat(input logic [7:0] base);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[i*8 +: 8] = base + 8'(i);
        return d;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a request from IDLE; returns at the COMPARE cycle.
    task automatic req(input logic we, input logic [31:0] addr, input logic [7:0] wd, input logic hold);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        tick();
        if (!hold) begin
            cpu_req = 1'b0; cpu_addr = 32'hDEAD_BEEF; cpu_wdata = 8'h5A;
        end
    endtask

    // Bounded wait for cpu_done; pops the expected read byte, then steps into IDLE.
    task automatic wait_done(input int exp_lat, input string tag);
        int n = 0;
        logic [7:0] e;
        while (!cpu_done && n < 40) begin tick(); n++; end
        chk({tag, "_done"}, 32'(cpu_done), 32'd1);
        if (exp_lat >= 0) chk({tag, "_lat"}, n, exp_lat);
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(e));
        tick();
    endtask

    // From COMPARE of a miss: check the fetch request, ack after dly cycles, check the fill.
    task automatic fetch(input logic [31:0] exp_addr, input logic [7:0] base, input int dly, input string tag);
        tick();
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        repeat (dly) tick();
        mem_ack = 1'b1; mem_rdata = pat(base);
        tick();
        mem_ack = 1'b0; mem_rdata = 256'h0;
        chk({tag, "_setout"}, 32'(c_set_out), 32'd1);
        chk({tag, "_viv"}, 32'(c_viv), 32'd1);
        chk({tag, "_fillhit"}, 32'(c_hit), 32'd0);
        chk({tag, "_filldec"}, 32'(c_dec), 32'(8'b1 << exp_addr[7:5]));
    endtask

    initial begin
        int r0, f0;
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_dec", 32'(c_dec), 32'h01);
        chk("rst_tag", 32'(c_tag), 32'h0);
        chk("rst_done", 32'(cpu_done), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        chk("rst_fill", 32'(c_fill[31:0]), 32'h0);
        reset = 1'b0; set_init = 1'b0;
        tick();

        // Cold load miss on line 1, fill, re-lookup hit.
        sb.push_back(8'h03);
        req(1'b0, 32'h0000_0123, 8'h00, 1'b0);
        chk("ld1_dec", 32'(c_dec), 32'h02);
        chk("ld1_off", 32'(c_offset), 32'h03);
        fetch(32'h0000_0120, 8'h00, 2, "ld1");
        wait_done(2, "ld1");

        // Same load now hits: done two cycles after the request, no memory traffic.
        sb.push_back(8'h03);
        r0 = req_cnt;
        req(1'b0, 32'h0000_0123, 8'h00, 1'b0);
        wait_done(1, "ld2");
        chk("ld2_noreq", req_cnt - r0, 0);
`ifdef CACHE_CTRL_STATS_EN
        chk("stat_miss", 32'(miss_count), 32'd1);
        chk("stat_hit", 32'(hit_count), 32'd1);
`endif

        // Store hit: set write strobes, then write-through; rdata holds the last load.
        sb.push_back(8'h03);
        req(1'b1, 32'h0000_0125, 8'hAB, 1'b0);
        chk("st_hit", 32'(c_hit), 32'd1);
        chk("st_mw", 32'(c_mem_write), 32'd1);
        chk("st_byte", 32'(c_byte), 32'hAB);
        tick();
        chk("st_hit_off", 32'(c_hit | c_mem_write), 32'd0);
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h0000_0125);
        chk("st_wdata", 32'(mem_wdata), 32'hAB);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        wait_done(0, "st");

        // Load the stored byte twice with cpu_req held through DONE.
        sb.push_back(8'hAB); sb.push_back(8'hAB);
        r0 = req_cnt;
        req(1'b0, 32'h0000_0125, 8'h00, 1'b1);
        wait_done(1, "ld3a");
        chk("hold_idle", 32'(cpu_done), 32'd0);
        tick();
        cpu_req = 1'b0;
        wait_done(1, "ld3b");
        chk("ld3_noreq", req_cnt - r0, 0);

        // Conflicting tag on the same index evicts line 1.
        sb.push_back(8'h43);
        req(1'b0, 32'h0001_0123, 8'h00, 1'b0);
        fetch(32'h0001_0120, 8'h40, 0, "ld4");
        wait_done(2, "ld4");
        sb.push_back(8'h03);
        req(1'b0, 32'h0000_0123, 8'h00, 1'b0);
        fetch(32'h0000_0120, 8'h00, 1, "ld5");
        wait_done(2, "ld5");

        // Reset mid-fetch: request drops at once and a late ack is ignored.
        req(1'b0, 32'h0002_0100, 8'h00, 1'b0);
        tick();
        chk("rf_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rf_req_drop", 32'(mem_req), 32'd0);
        chk("rf_dec", 32'(c_dec), 32'h01);
        tick();
        reset = 1'b0;
        f0 = fill_cnt;
        mem_ack = 1'b1; mem_rdata = pat(8'h80);
        tick();
        mem_ack = 1'b0; mem_rdata = 256'h0;
        repeat (3) tick();
        chk("rf_nofill", fill_cnt - f0, 0);
        chk("rf_idle_req", 32'(mem_req), 32'd0);
        chk("rf_idle_done", 32'(cpu_done), 32'd0);
        chk("rf_rdata", 32'(cpu_rdata), 32'h0);

        // No ack: timeout after 8 FETCH cycles, rdata unchanged.
        sb.push_back(8'h00);
        req(1'b0, 32'h0003_0100, 8'h00, 1'b0);
        tick();
        chk("to_req", 32'(mem_req), 32'd1);
        chk("to_err0", 32'(mem_err), 32'd0);
        wait_done(8, "to");
        chk("to_err1", 32'(mem_err), 32'd1);
        chk("to_req_drop", 32'(mem_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
